// File: rtl/core_cluster_mem_arbiter.sv
// Round-robin arbiter that shares one DRAM request port among NUM_CORES cores.
// It tags each granted request with the core id, limits in-flight reads per core,
// and steers tagged read responses back to the core that issued them.
module core_cluster_mem_arbiter #(
  parameter int unsigned NUM_CORES       = 4,
  parameter int unsigned ADDR_W          = 21,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TAG_W           = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  output logic [NUM_CORES-1:0]          core_req_ready,
  input  logic [NUM_CORES-1:0]          core_req_write,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_req_wdata,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [DATA_W-1:0]             core_resp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_write,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_wdata,
  output logic [TAG_W-1:0]              mem_req_tag,
  input  logic                          mem_resp_valid,
  input  logic [TAG_W-1:0]              mem_resp_tag,
  input  logic [DATA_W-1:0]             mem_resp_rdata,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(NUM_CORES);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW:0] NumCores = (PtrW + 1)'(NUM_CORES);
  localparam logic [PtrW-1:0] LastCore = PtrW'(NUM_CORES - 1);

  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q [NUM_CORES];
  logic [CntW-1:0]      cnt_d [NUM_CORES];
  logic                 req_valid_q, req_write_q;
  logic [ADDR_W-1:0]    req_addr_q;
  logic [DATA_W-1:0]    req_wdata_q;
  logic [TAG_W-1:0]     req_tag_q;
  logic [NUM_CORES-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_rdata_q;

  logic [NUM_CORES-1:0] eligible, cnt_inc, cnt_dec, cnt_nz;
  logic                 can_load, found, grant, tag_in_range, resp_ok;
  logic [PtrW-1:0]      win, resp_idx;
  logic [PtrW:0]        idx;

  // Output register may take a new request when empty or draining this cycle.
  assign can_load = ~req_valid_q | mem_req_ready;

  // Per-core eligibility: writes always, reads only below the in-flight limit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      eligible[i] = core_req_valid[i] & (core_req_write[i] | (cnt_q[i] < MaxCnt));
    end
  end

  // Round-robin search from ptr_q, wrapping modulo NUM_CORES.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (idx >= NumCores) idx = idx - NumCores;
      if (!found && eligible[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
    grant = found & can_load;
  end

  // One-hot ready for the winner; held low while reset is asserted.
  always_comb begin
    core_req_ready = '0;
    if (grant && reset_n) core_req_ready[win] = 1'b1;
  end

  // Response legality, counter next-state and pointer advance.
  always_comb begin
    resp_idx     = mem_resp_tag[PtrW-1:0];
    tag_in_range = 32'(mem_resp_tag) < NUM_CORES;
    resp_ok      = mem_resp_valid & tag_in_range & (cnt_q[resp_idx] != '0);
    resp_valid_d = '0;
    if (resp_ok) resp_valid_d[resp_idx] = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt_inc[i] = grant & (win == PtrW'(i)) & ~core_req_write[i];
      cnt_dec[i] = resp_ok & (resp_idx == PtrW'(i));
      cnt_nz[i]  = cnt_q[i] != '0;
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (cnt_dec[i] && !cnt_inc[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    ptr_d = ptr_q;
    if (grant) ptr_d = (win == LastCore) ? '0 : win + 1'b1;
  end

  // State: request register, counters, pointer and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_tag_q    <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      if (resp_ok) resp_rdata_q <= mem_resp_rdata;
      if (can_load) begin
        req_valid_q <= grant;
        if (grant) begin
          req_write_q <= core_req_write[win];
          req_addr_q  <= core_req_addr[win*ADDR_W +: ADDR_W];
          req_wdata_q <= core_req_wdata[win*DATA_W +: DATA_W];
          req_tag_q   <= TAG_W'(win);
        end
      end
      // Unsolicited or out-of-range responses are dropped.
      if (mem_resp_valid) begin
        assert (resp_ok)
          else $warning("dropped unexpected response, tag %0d", mem_resp_tag);
      end
    end
  end

  assign mem_req_valid   = req_valid_q;
  assign mem_req_write   = req_write_q;
  assign mem_req_addr    = req_addr_q;
  assign mem_req_wdata   = req_wdata_q;
  assign mem_req_tag     = req_tag_q;
  assign core_resp_valid = resp_valid_q;
  assign core_resp_rdata = resp_rdata_q;
  assign busy            = req_valid_q | (|cnt_nz);

endmodule

// File: tb/tb_core_cluster_mem_arbiter.sv
// Directed bench for core_cluster_mem_arbiter with its default parameters.
module tb_core_cluster_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   core_req_valid, core_req_ready, core_req_write, core_resp_valid;
  logic [83:0]  core_req_addr;
  logic [255:0] core_req_wdata;
  logic [63:0]  core_resp_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_write;
  logic [20:0]  mem_req_addr;
  logic [63:0]  mem_req_wdata;
  logic [3:0]   mem_req_tag;
  logic         mem_resp_valid;
  logic [3:0]   mem_resp_tag;
  logic [63:0]  mem_resp_rdata;
  logic         busy;

  int tests = 0;
  int fails = 0;

  core_cluster_mem_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_write  (core_req_write),
    .core_req_addr   (core_req_addr),
    .core_req_wdata  (core_req_wdata),
    .core_resp_valid (core_resp_valid),
    .core_resp_rdata (core_resp_rdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_tag     (mem_req_tag),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_tag    (mem_resp_tag),
    .mem_resp_rdata  (mem_resp_rdata),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [20:0] a,
                         input logic [63:0] d);
    core_req_valid[i]          = 1'b1;
    core_req_write[i]          = wr;
    core_req_addr[i*21 +: 21]  = a;
    core_req_wdata[i*64 +: 64] = d;
  endtask

  initial begin
    reset_n        = 1'b0;
    core_req_valid = '0;
    core_req_write = '0;
    core_req_addr  = '0;
    core_req_wdata = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_tag   = '0;
    mem_resp_rdata = '0;
    #2;
    chk("rst_mvalid", mem_req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp", core_resp_valid, 4'b0000);
    chk("rst_ready", core_req_ready, 4'b0000);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Reset mid-stream: core 0 wins, register held, then async reset.
    set_req(0, 1'b0, 21'h100, 64'h0);
    set_req(1, 1'b0, 21'h101, 64'h0);
    set_req(2, 1'b0, 21'h102, 64'h0);
    #1;
    chk("mid_ready0", core_req_ready, 4'b0001);
    tick();
    chk("mid_mvalid", mem_req_valid, 1'b1);
    chk("mid_tag", mem_req_tag, 4'd0);
    chk("mid_addr", mem_req_addr, 21'h100);
    chk("mid_busy", busy, 1'b1);
    chk("mid_stall", core_req_ready, 4'b0000);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", mem_req_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", core_req_ready, 4'b0000);
    reset_n = 1'b1;
    #1;
    chk("mid_restart", core_req_ready, 4'b0001);
    core_req_valid = '0;
    tick();
    chk("mid_idle", mem_req_valid, 1'b0);

    // Fairness: all four cores read, responses two cycles after each grant.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 21'(32'h200 + i), 64'h0);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 4'((k - 2) % 4);
        mem_resp_rdata = 64'(k);
      end
      #1;
      chk("fair_ready", core_req_ready, 64'(1 << (k % 4)));
      if (k >= 1) begin
        chk("fair_mvalid", mem_req_valid, 1'b1);
        chk("fair_tag", mem_req_tag, 64'((k - 1) % 4));
        chk("fair_addr", mem_req_addr, 64'(32'h200 + (k - 1) % 4));
      end
      if (k >= 3) begin
        chk("fair_resp", core_resp_valid, 64'(1 << ((k - 3) % 4)));
        chk("fair_rdata", core_resp_rdata, 64'(k - 1));
      end
      tick();
    end
    core_req_valid = '0;
    mem_resp_tag   = 4'd2;
    mem_resp_rdata = 64'd8;
    #1;
    chk("fair_last_tag", mem_req_tag, 4'd3);
    chk("fair_resp7", core_resp_valid, 4'b0010);
    chk("fair_rdata7", core_resp_rdata, 64'd7);
    tick();
    mem_resp_tag   = 4'd3;
    mem_resp_rdata = 64'd9;
    #1;
    chk("fair_drained", mem_req_valid, 1'b0);
    chk("fair_resp8", core_resp_valid, 4'b0100);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("fair_resp9", core_resp_valid, 4'b1000);
    chk("fair_rdata9", core_resp_rdata, 64'd9);
    chk("fair_busy", busy, 1'b0);
    tick();
    chk("fair_resp_off", core_resp_valid, 4'b0000);

    // Backpressure: core 2 write held for five stalled cycles (pointer is 0).
    mem_req_ready = 1'b0;
    set_req(2, 1'b1, 21'h1F000, 64'hDEADBEEF_CAFEF00D);
    #1;
    chk("bp_ready", core_req_ready, 4'b0100);
    tick();
    core_req_valid = '0;
    set_req(0, 1'b1, 21'h10, 64'h1);
    set_req(1, 1'b1, 21'h20, 64'h2);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_mvalid", mem_req_valid, 1'b1);
      chk("bp_write", mem_req_write, 1'b1);
      chk("bp_addr", mem_req_addr, 21'h1F000);
      chk("bp_wdata", mem_req_wdata, 64'hDEADBEEF_CAFEF00D);
      chk("bp_tag", mem_req_tag, 4'd2);
      chk("bp_noready", core_req_ready, 4'b0000);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("bp_drain_ready", core_req_ready, 4'b0001);
    tick();
    chk("bp_next_tag", mem_req_tag, 4'd0);
    chk("bp_next_addr", mem_req_addr, 21'h10);
    core_req_valid = '0;
    tick();
    chk("bp_empty", mem_req_valid, 1'b0);

    // Outstanding limit on core 1 (pointer is 1).
    set_req(1, 1'b0, 21'h40, 64'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("lim_grant", core_req_ready, 4'b0010);
      tick();
    end
    #1;
    chk("lim_stall", core_req_ready, 4'b0000);
    tick();
    chk("lim_stall2", core_req_ready, 4'b0000);
    chk("lim_mvalid", mem_req_valid, 1'b0);
    chk("lim_busy", busy, 1'b1);
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd1;
    mem_resp_rdata = 64'h1234;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("lim_resp", core_resp_valid, 4'b0010);
    chk("lim_rdata", core_resp_rdata, 64'h1234);
    chk("lim_fifth", core_req_ready, 4'b0010);
    tick();
    // Counter is back at 4; return two responses to bring it to 2.
    chk("lim_fifth_tag", mem_req_tag, 4'd1);
    core_req_valid = '0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h11;
    tick();
    mem_resp_rdata = 64'h22;
    #1;
    chk("sim_rdata11", core_resp_rdata, 64'h11);
    tick();
    // Counter at 2: read grant and matching response in the same cycle.
    set_req(1, 1'b0, 21'h44, 64'h0);
    mem_resp_rdata = 64'h33;
    #1;
    chk("sim_ready", core_req_ready, 4'b0010);
    chk("sim_rdata22", core_resp_rdata, 64'h22);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("sim_keep2a", core_req_ready, 4'b0010);
    chk("sim_resp", core_resp_valid, 4'b0010);
    chk("sim_rdata33", core_resp_rdata, 64'h33);
    tick();
    chk("sim_keep2b", core_req_ready, 4'b0010);
    tick();
    chk("sim_full", core_req_ready, 4'b0000);
    core_req_valid = '0;
    mem_resp_valid = 1'b1;
    repeat (4) tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("sim_busy", busy, 1'b0);

    // Skip/wrap: move pointer to 1 via a core 0 write, then only core 3 reads.
    set_req(0, 1'b1, 21'h50, 64'h55);
    #1;
    chk("wrap_c0", core_req_ready, 4'b0001);
    tick();
    core_req_valid = '0;
    set_req(3, 1'b0, 21'h1FFFFF, 64'h0);
    #1;
    chk("wrap_c3", core_req_ready, 4'b1000);
    tick();
    core_req_valid = '0;
    set_req(1, 1'b1, 21'h60, 64'h0);
    set_req(3, 1'b1, 21'h61, 64'h0);
    #1;
    chk("wrap_tag", mem_req_tag, 4'd3);
    chk("wrap_addr", mem_req_addr, 21'h1FFFFF);
    chk("wrap_ptr0", core_req_ready, 4'b0010);
    core_req_valid = '0;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 4'd2;
    mem_resp_rdata = 64'hBAD;
    tick();
    mem_resp_tag   = 4'd5;
    mem_resp_rdata = 64'hBAD2;
    #1;
    chk("unsol_tag2", core_resp_valid, 4'b0000);
    tick();
    mem_resp_tag   = 4'd3;
    mem_resp_rdata = 64'h77;
    #1;
    chk("unsol_tag5", core_resp_valid, 4'b0000);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("wrap_resp3", core_resp_valid, 4'b1000);
    chk("wrap_rdata3", core_resp_rdata, 64'h77);
    chk("end_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
